// File: rtl/dm_access_unit.sv
// dm_access_unit: MEM-stage load/store bridge to a variable-latency SRAM with
// lane steering, load extension, misalign detection and access timeout.
module dm_access_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_misalign,
    output logic        mem_err,
    output logic        mem_req,
    output logic        mem_web,
    output logic [31:0] mem_bweb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di,
    input  logic        mem_ack,
    input  logic [31:0] mem_do
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q, rdata_q, byte_sh, ext;
    logic [15:0] half_v;
    logic [2:0]  f3_q;
    logic        we_q, mis_q, tmo_q, legal, misal, st;

    always_comb begin
        legal = cpu_we ? (cpu_funct3 inside {3'd0, 3'd1, 3'd2})
                       : (cpu_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misal = (cpu_funct3[1:0] == 2'b01 && cpu_addr[0]) ||
                (cpu_funct3[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00);
        byte_sh = mem_do >> {addr_q[1:0], 3'b000};
        half_v = addr_q[1] ? mem_do[31:16] : mem_do[15:0];
        ext = f3_q[1:0] == 2'b00 ? {{24{byte_sh[7] & ~f3_q[2]}}, byte_sh[7:0]} :
              f3_q[1:0] == 2'b01 ? {{16{half_v[15] & ~f3_q[2]}}, half_v} : mem_do;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cpu_req) begin
                    we_q  <= cpu_we;
                    tmo_q <= 1'b0;
                    mis_q <= !legal || misal;
                    if (legal && !misal) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        f3_q    <= cpu_funct3;
                        state   <= ISSUE;
                    end else begin
                        state <= DONE;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (mem_ack) rdata_q <= ext;
                    state <= mem_ack ? DONE : WAIT;
                end
                WAIT: begin
                    // an ack in the final wait cycle still completes the access
                    if (mem_ack) begin
                        rdata_q <= ext;
                        state   <= DONE;
                    end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                        tmo_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign st           = state == ISSUE && we_q;
    assign cpu_stall    = (state == IDLE && cpu_req) || state == ISSUE || state == WAIT;
    assign cpu_done     = state == DONE;
    assign cpu_misalign = cpu_done && mis_q;
    assign mem_err      = cpu_done && tmo_q;
    assign cpu_rdata    = (cpu_done && !we_q && !mis_q && !tmo_q) ? rdata_q : '0;
    assign mem_req      = state == ISSUE;
    assign mem_web      = !st;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_di       = !st ? '0 :
                          f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                          f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign mem_bweb     = !st ? '1 :
                          f3_q[1:0] == 2'b00 ? ~(32'hFF << {addr_q[1:0], 3'b000}) :
                          f3_q[1:0] == 2'b01 ? (addr_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000) : '0;
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: directed checks of dm_access_unit with TIMEOUT_CYC=5.
module tb_dm_access_unit;
    localparam int TO = 5;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, mem_ack = 1'b0;
    logic [2:0]  cpu_funct3 = '0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_do = '0;
    logic        cpu_stall, cpu_done, cpu_misalign, mem_err, mem_req, mem_web;
    logic [31:0] cpu_rdata, mem_bweb, mem_addr, mem_di;
    int          nchk = 0, nerr = 0, lat, nreq, total;
    logic        stall_ok, d_mis, d_err, d_stall, i_web;
    logic [31:0] d_rdata, i_bweb, i_addr, i_di;

    dm_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cpu_misalign(cpu_misalign), .mem_err(mem_err), .mem_req(mem_req),
        .mem_web(mem_web), .mem_bweb(mem_bweb), .mem_addr(mem_addr),
        .mem_di(mem_di), .mem_ack(mem_ack), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ack_k: cycles after the mem_req cycle at which mem_ack is raised (0 = ISSUE cycle)
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_k, input logic [31:0] dout);
        int k;
        cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
        mem_do = dout;
        #1;
        stall_ok = cpu_stall;
        lat = 0; nreq = 0; k = -1;
        while (!cpu_done && lat < 100) begin
            tick();
            lat++;
            if (mem_req) begin
                k = 0; nreq++;
                i_web = mem_web; i_bweb = mem_bweb; i_addr = mem_addr; i_di = mem_di;
            end else if (k >= 0) k++;
            if (!cpu_done) stall_ok &= cpu_stall;
            mem_ack = k >= 0 && k == ack_k && !cpu_done;
        end
        if (lat >= 100) begin
            nchk++; nerr++;
            $error("FAIL done_wait observed=timeout expected=cpu_done");
        end
        d_rdata = cpu_rdata; d_mis = cpu_misalign; d_err = mem_err; d_stall = cpu_stall;
        cpu_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("done_pulse", cpu_done, 0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_stall", cpu_stall, 0);
        chk("rst_done", cpu_done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_web", mem_web, 1);
        chk("rst_bweb", mem_bweb, 32'hFFFF_FFFF);
        chk("rst_addr", mem_addr, 0);
        chk("rst_di", mem_di, 0);
        chk("rst_rdata", cpu_rdata, 0);
        rst = 1'b1;
        tick();

        access(1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 0);
        chk("sw_lat", lat, 5);
        chk("sw_nreq", nreq, 1);
        chk("sw_addr", i_addr, 32'h100);
        chk("sw_web", i_web, 0);
        chk("sw_bweb", i_bweb, 0);
        chk("sw_di", i_di, 32'hDEADBEEF);
        chk("sw_stall", stall_ok, 1);
        chk("sw_done_stall", d_stall, 0);
        chk("sw_err", d_err, 0);
        chk("sw_rdata", d_rdata, 0);

        access(1, 3'b000, 32'h103, 32'h000000A5, 0, 0);
        chk("sb_bweb", i_bweb, 32'h00FF_FFFF);
        chk("sb_di", i_di, 32'hA5A5A5A5);
        chk("sb_addr", i_addr, 32'h100);

        access(1, 3'b001, 32'h102, 32'h0000BEEF, 1, 0);
        chk("sh_bweb", i_bweb, 32'h0000_FFFF);
        chk("sh_di", i_di, 32'hBEEFBEEF);

        access(0, 3'b000, 32'h201, 0, 2, 32'h12348000);
        chk("lb_rdata", d_rdata, 32'hFFFFFF80);
        chk("lb_addr", i_addr, 32'h200);
        chk("lb_web", i_web, 1);
        chk("lb_bweb", i_bweb, 32'hFFFF_FFFF);
        chk("lb_di", i_di, 0);
        access(0, 3'b100, 32'h201, 0, 0, 32'h12348000);
        chk("lbu_rdata", d_rdata, 32'h00000080);
        access(0, 3'b101, 32'h202, 0, 0, 32'h12348000);
        chk("lhu_rdata", d_rdata, 32'h00001234);
        access(0, 3'b001, 32'h202, 0, 0, 32'h8765_4321);
        chk("lh_rdata", d_rdata, 32'hFFFF8765);

        access(0, 3'b001, 32'h203, 0, 0, 32'h12348000);
        chk("lh_mis_lat", lat, 1);
        chk("lh_mis_flag", d_mis, 1);
        chk("lh_mis_nreq", nreq, 0);
        chk("lh_mis_rdata", d_rdata, 0);
        access(0, 3'b011, 32'h200, 0, 0, 32'h12348000);
        chk("f3_ill_lat", lat, 1);
        chk("f3_ill_flag", d_mis, 1);
        chk("f3_ill_nreq", nreq, 0);
        access(0, 3'b010, 32'h202, 0, 0, 0);
        chk("lw_mis_flag", d_mis, 1);

        access(0, 3'b010, 32'h300, 0, 1000, 32'h11112222);
        chk("tmo_lat", lat, TO + 2);
        chk("tmo_err", d_err, 1);
        chk("tmo_rdata", d_rdata, 0);
        chk("tmo_mis", d_mis, 0);
        access(0, 3'b010, 32'h304, 0, TO, 32'hCAFEF00D);
        chk("race_lat", lat, TO + 2);
        chk("race_err", d_err, 0);
        chk("race_rdata", d_rdata, 32'hCAFEF00D);

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h400;
        tick(); tick(); tick();
        chk("rw_in_wait", cpu_stall, 1);
        rst = 1'b0; cpu_req = 1'b0;
        tick();
        rst = 1'b1; mem_ack = 1'b1; mem_do = 32'h55AA55AA;
        chk("rw_req", mem_req, 0);
        chk("rw_stall", cpu_stall, 0);
        chk("rw_addr", mem_addr, 0);
        tick();
        mem_ack = 1'b0;
        chk("rw_done", cpu_done, 0);
        chk("rw_rdata", cpu_rdata, 0);
        chk("rw_req2", mem_req, 0);
        access(0, 3'b010, 32'h408, 0, 2, 32'h0BADC0DE);
        chk("rw_lw_rdata", d_rdata, 32'h0BADC0DE);

        access(0, 3'b010, 32'h500, 0, 0, 32'h13579BDF);
        total = nreq;
        chk("b2b_lw_lat", lat, 2);
        chk("b2b_lw_rdata", d_rdata, 32'h13579BDF);
        access(1, 3'b010, 32'h504, 32'h2468ACE0, 0, 0);
        total += nreq;
        chk("b2b_sw_lat", lat, 2);
        chk("b2b_nreq", total, 2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
